// File: rtl/transfer_pkg.sv
// -----------------------------------------------------------------------------
// transfer_pkg
// Shared definitions for the transfer_4to1 parallel-to-serial converter:
// the default word width, the FSM state encoding and a helper that sizes
// the bit counter for a given word width.
// -----------------------------------------------------------------------------
package transfer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } stateT;

    // Counter must index bits 0..width-1; a 2-bit word still needs one bit.
    function automatic int cntWidth(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/transfer_hold_buf.sv
// -----------------------------------------------------------------------------
// transfer_hold_buf
// One-entry holding register with a full flag. It parks the next word while
// the shifter is still busy with the current one, so words can stream
// back-to-back with no idle cycle on the serial side.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset, empties the buffer
//   load_i    capture data_i and mark the buffer full
//   unload_i  the shifter has taken the word, mark the buffer empty
//   data_i    word to park
//   data_o    parked word
//   full_o    buffer holds a word
// -----------------------------------------------------------------------------
module transfer_hold_buf
    import transfer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             unload_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o
);

    logic [WIDTH-1:0] holdData_q;
    logic             holdFull_q;

    // Load and unload never coincide: a load needs an empty buffer and an
    // unload needs a full one, so load simply takes precedence here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            holdData_q <= '0;
            holdFull_q <= 1'b0;
        end else if (load_i) begin
            holdData_q <= data_i;
            holdFull_q <= 1'b1;
        end else if (unload_i) begin
            holdFull_q <= 1'b0;
        end
    end

    assign data_o = holdData_q;
    assign full_o = holdFull_q;

endmodule

// File: rtl/transfer_4to1.sv
// -----------------------------------------------------------------------------
// transfer_4to1
// Parallel-to-serial converter. Words arrive over a valid/ready handshake and
// leave one bit per clock with first/last frame markers. A one-entry holding
// buffer lets consecutive words stream without a gap, so d_out can drive the
// matching 1-to-4 deserializer directly.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   d_in       parallel word to transmit
//   d_in_vld   d_in holds a valid word
//   d_in_rdy   block can accept a word this cycle
//   d_out      serial data bit
//   d_out_vld  d_out carries a valid bit
//   d_first    d_out is the first bit of a word
//   d_last     d_out is the final bit of a word
//   busy       shifter active or holding buffer occupied
// -----------------------------------------------------------------------------
module transfer_4to1
    import transfer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_in_vld,
    output logic             d_in_rdy,
    output logic             d_out,
    output logic             d_out_vld,
    output logic             d_first,
    output logic             d_last,
    output logic             busy
);

    localparam int             CW   = cntWidth(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    stateT            state_q,    state_d;
    logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
    logic [CW-1:0]    bitCnt_q,   bitCnt_d;
    logic             dOut_q,     dOut_d;
    logic             dOutVld_q,  dOutVld_d;
    logic             dFirst_q,   dFirst_d;
    logic             dLast_q,    dLast_d;
    logic             busy_q,     busy_d;

    logic             accept;
    logic             holdLoad;
    logic             holdUnload;
    logic             holdFull;
    logic             holdFullNext;
    logic [WIDTH-1:0] holdData;

    // Holding buffer: parks a word accepted while the shifter is mid-word.
    transfer_hold_buf #(
        .WIDTH(WIDTH)
    ) holdBuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (holdLoad),
        .unload_i (holdUnload),
        .data_i   (d_in),
        .data_o   (holdData),
        .full_o   (holdFull)
    );

    assign d_in_rdy = rst_n & ~holdFull;
    assign accept   = d_in_vld & d_in_rdy;

    // Next-state logic. The registered outputs are derived from the next
    // shifter/counter values so bit 0 of a word appears on d_out the cycle
    // right after it is accepted. At the last bit the held word wins over a
    // fresh one; a fresh accept there is only possible with the buffer empty,
    // so it bypasses straight into the shifter.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        bitCnt_d   = bitCnt_q;
        holdLoad   = 1'b0;
        holdUnload = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = SHIFT;
                    shiftReg_d = d_in;
                    bitCnt_d   = '0;
                end
            end
            SHIFT: begin
                if (bitCnt_q == LAST) begin
                    if (holdFull) begin
                        holdUnload = 1'b1;
                        shiftReg_d = holdData;
                        bitCnt_d   = '0;
                    end else if (accept) begin
                        shiftReg_d = d_in;
                        bitCnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shiftReg_d = MSB_FIRST ? (shiftReg_q << 1) : (shiftReg_q >> 1);
                    bitCnt_d   = bitCnt_q + CW'(1);
                    holdLoad   = accept;
                end
            end
            default: state_d = IDLE;
        endcase

        holdFullNext = holdLoad | (holdFull & ~holdUnload);
        dOutVld_d    = (state_d == SHIFT);
        dOut_d       = dOutVld_d & (MSB_FIRST ? shiftReg_d[WIDTH-1] : shiftReg_d[0]);
        dFirst_d     = dOutVld_d & (bitCnt_d == '0);
        dLast_d      = dOutVld_d & (bitCnt_d == LAST);
        busy_d       = dOutVld_d | holdFullNext;
    end

    // State and output registers; reset discards any partial or held word
    // and quiets the serial side on the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            bitCnt_q   <= '0;
            dOut_q     <= 1'b0;
            dOutVld_q  <= 1'b0;
            dFirst_q   <= 1'b0;
            dLast_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            bitCnt_q   <= bitCnt_d;
            dOut_q     <= dOut_d;
            dOutVld_q  <= dOutVld_d;
            dFirst_q   <= dFirst_d;
            dLast_q    <= dLast_d;
            busy_q     <= busy_d;
        end
    end

    assign d_out     = dOut_q;
    assign d_out_vld = dOutVld_q;
    assign d_first   = dFirst_q;
    assign d_last    = dLast_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_transfer_4to1.sv
// -----------------------------------------------------------------------------
// tb_transfer_4to1
// Scoreboard bench for transfer_4to1. Two instances share clock and reset:
// one MSB-first, one LSB-first. Stimulus pushes the expected serial bits (and,
// for the MSB-first instance, the expected word) when a word is accepted;
// independent monitors pop and compare whenever d_out_vld is high. The
// MSB-first monitor also reassembles words the way the 1-to-4 deserializer
// would and compares them in order.
// -----------------------------------------------------------------------------
module tb_transfer_4to1;

    typedef struct packed {
        logic d;
        logic first;
        logic last;
    } expBitT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [3:0] dIn = '0;
    logic       dInVld = 1'b0;
    logic       dInRdy, dOut, dOutVld, dFirst, dLast, busy;

    logic [3:0] dInL = '0;
    logic       dInVldL = 1'b0;
    logic       dInRdyL, dOutL, dOutVldL, dFirstL, dLastL, busyL;

    expBitT     expQ[$];
    expBitT     expQL[$];
    logic [3:0] wordQ[$];

    int         checks = 0;
    int         errors = 0;
    int         cycleCnt = 0;
    int         acceptCycle = 0;
    int         lastBitCycle = 0;
    logic [3:0] assembled = '0;

    transfer_4to1 #(.WIDTH(4), .MSB_FIRST(1'b1)) dutMsb (
        .clk(clk), .rst_n(rst_n), .d_in(dIn), .d_in_vld(dInVld), .d_in_rdy(dInRdy),
        .d_out(dOut), .d_out_vld(dOutVld), .d_first(dFirst), .d_last(dLast), .busy(busy)
    );

    transfer_4to1 #(.WIDTH(4), .MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .rst_n(rst_n), .d_in(dInL), .d_in_vld(dInVldL), .d_in_rdy(dInRdyL),
        .d_out(dOutL), .d_out_vld(dOutVldL), .d_first(dFirstL), .d_last(dLastL), .busy(busyL)
    );

    // 100 MHz-style clock and a free-running cycle counter for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Watchdog so a stuck run still ends with a visible failure.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Shared comparison: counts every check and reports any mismatch.
    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected serial image of a 4-bit word for either bit order.
    task automatic pushExpected(input logic [3:0] w, input bit lsbSel);
        expBitT e;
        for (int i = 0; i < 4; i++) begin
            e.d     = lsbSel ? w[i] : w[3-i];
            e.first = (i == 0);
            e.last  = (i == 3);
            if (lsbSel) expQL.push_back(e);
            else        expQ.push_back(e);
        end
        if (!lsbSel) wordQ.push_back(w);
    endtask

    // Present a word at the falling edge and hold it until ready is seen;
    // stalls counts the cycles ready was low before the word went in.
    task automatic applyStimulus(input logic [3:0] w, input bit lsbSel, output int stalls);
        bit accepted;
        bit rdy;
        accepted = 1'b0;
        stalls   = 0;
        @(negedge clk);
        if (lsbSel) begin dInL = w; dInVldL = 1'b1; end
        else        begin dIn  = w; dInVld  = 1'b1; end
        while (!accepted && stalls < 50) begin
            rdy = lsbSel ? dInRdyL : dInRdy;
            if (rdy) begin
                accepted    = 1'b1;
                acceptCycle = cycleCnt;
                pushExpected(w, lsbSel);
            end
            @(posedge clk);
            if (!accepted) begin
                stalls++;
                @(negedge clk);
            end
        end
        if (!accepted) checkOutput("accept timeout", 0, 1);
    endtask

    task automatic dropValid();
        @(negedge clk);
        dInVld  = 1'b0;
        dInVldL = 1'b0;
    endtask

    // Wait (bounded) until every expected bit and word has been consumed.
    task automatic waitDrain();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((expQ.size() != 0 || expQL.size() != 0 || wordQ.size() != 0) && n < 100);
        checkOutput("drain", expQ.size() + expQL.size() + wordQ.size(), 0);
    endtask

    // MSB-first monitor: bit-level scoreboard plus word reassembly.
    always @(negedge clk) begin
        expBitT e;
        logic [3:0] w;
        if (dOutVld) begin
            if (expQ.size() == 0) begin
                checkOutput("msb unexpected valid", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("msb d_out", int'(dOut), int'(e.d));
                checkOutput("msb d_first", int'(dFirst), int'(e.first));
                checkOutput("msb d_last", int'(dLast), int'(e.last));
            end
            assembled = dFirst ? {3'b000, dOut} : {assembled[2:0], dOut};
            if (dLast) begin
                lastBitCycle = cycleCnt;
                if (wordQ.size() == 0) begin
                    checkOutput("word unexpected", 1, 0);
                end else begin
                    w = wordQ.pop_front();
                    checkOutput("word reassembled", int'(assembled), int'(w));
                end
            end
        end
    end

    // LSB-first monitor: bit-level scoreboard only.
    always @(negedge clk) begin
        expBitT e;
        if (dOutVldL) begin
            if (expQL.size() == 0) begin
                checkOutput("lsb unexpected valid", 1, 0);
            end else begin
                e = expQL.pop_front();
                checkOutput("lsb d_out", int'(dOutL), int'(e.d));
                checkOutput("lsb d_first", int'(dFirstL), int'(e.first));
                checkOutput("lsb d_last", int'(dLastL), int'(e.last));
            end
        end
    end

    // Directed sequence: reset, single words in both orders, back-to-back
    // streaming, reset mid-word, then a random stream for the word checker.
    initial begin
        int k;
        int s0, s1, s2;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset d_out", int'(dOut), 0);
        checkOutput("reset d_out_vld", int'(dOutVld), 0);
        checkOutput("reset d_first", int'(dFirst), 0);
        checkOutput("reset d_last", int'(dLast), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset d_in_rdy", int'(dInRdy), 1);
        checkOutput("reset lsb d_out_vld", int'(dOutVldL), 0);

        $display("[TB] single word 1011 MSB first");
        applyStimulus(4'b1011, 1'b0, s0);
        k = acceptCycle;
        dropValid();
        waitDrain();
        checkOutput("single last-bit latency", lastBitCycle - k, 4);
        checkOutput("single idle after", int'(dOutVld), 0);
        checkOutput("single busy after", int'(busy), 0);

        $display("[TB] single word 1011 LSB first");
        applyStimulus(4'b1011, 1'b1, s0);
        dropValid();
        waitDrain();
        checkOutput("lsb idle after", int'(dOutVldL), 0);

        $display("[TB] back-to-back A, 5, F");
        applyStimulus(4'hA, 1'b0, s0);
        k = acceptCycle;
        applyStimulus(4'h5, 1'b0, s1);
        applyStimulus(4'hF, 1'b0, s2);
        dropValid();
        waitDrain();
        checkOutput("b2b last-bit latency", lastBitCycle - k, 12);
        checkOutput("b2b stalls word 5", s1, 0);
        checkOutput("b2b stalls word F", s2, 3);

        $display("[TB] reset in the middle of word C");
        applyStimulus(4'hC, 1'b0, s0);
        dropValid();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("bits left at reset", expQ.size(), 2);
        expQ.delete();
        wordQ.delete();
        @(negedge clk);
        checkOutput("midreset d_out_vld", int'(dOutVld), 0);
        checkOutput("midreset d_out", int'(dOut), 0);
        checkOutput("midreset d_last", int'(dLast), 0);
        checkOutput("midreset busy", int'(busy), 0);
        checkOutput("midreset d_in_rdy", int'(dInRdy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'h3, 1'b0, s0);
        dropValid();
        waitDrain();

        $display("[TB] random stream of 16 words");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 1'b0, s0);
        end
        dropValid();
        waitDrain();
        checkOutput("stream idle after", int'(dOutVld), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/transfer_4to1.md
Name: transfer_4to1

Overview:
Parallel-to-serial converter, the transmit counterpart of the 1-to-4 serial deserializer.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Shifts each word out one bit per clock, with first-bit and last-bit frame markers.
- A one-entry holding buffer lets back-to-back words stream with no idle gap, so the output can drive the deserializer's d_in directly.

Parameters:
WIDTH, 4, parallel word width in bits (≥2)
MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 first

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
d_in  input  WIDTH  parallel word to transmit
d_in_vld  input  1  d_in holds a valid word
d_in_rdy  output  1  block can accept a word this cycle
d_out  output  1  serial data bit
d_out_vld  output  1  d_out carries a valid bit
d_first  output  1  d_out is bit 0 of a word (frame start)
d_last  output  1  d_out is final bit of a word
busy  output  1  shifter active or holding buffer occupied

Behaviour:
- Clocking and reset:
  - Single clock domain. All state is sampled on the rising clk edge.
  - Reset is synchronous and active-low: while rst_n=0 at a clk edge, all registers clear.
- Reset values: state=IDLE, shift register=0, bit counter=0, hold_full=0. Outputs d_out=0, d_out_vld=0, d_first=0, d_last=0, busy=0.
- Ready and accept:
  - d_in_rdy = rst_n & ~hold_full (combinational). Words presented while rst_n=0 are ignored.
  - Accept = d_in_vld & d_in_rdy. d_in is captured only on accept.
- States:
  - IDLE: d_out_vld=0.
    - On accept, d_in loads into the shift register, counter←0, go to SHIFT.
    - Bit 0 appears on d_out the cycle after accept (latency 1).
  - SHIFT: d_out_vld=1, one bit per cycle, counter increments.
    - Accept while counter<WIDTH-1: word goes to the holding buffer, hold_full←1.
    - At counter=WIDTH-1 (last bit), in priority order:
      - hold_full=1: load the hold word into the shifter, clear hold_full, counter←0, stay in SHIFT.
      - else accept this cycle: bypass d_in straight into the shifter, counter←0, stay in SHIFT.
      - else: go to IDLE.
- Gapless streaming: continuous d_in_vld=1 gives d_out_vld=1 on every cycle after the first accept.
- Bit order: MSB_FIRST=1 drives d_out from shifter[WIDTH-1] with a left shift; MSB_FIRST=0 drives d_out from shifter[0] with a right shift.
- Output registers:
  - d_out, d_out_vld, d_first and d_last are registered.
  - d_first = d_out_vld & (counter==0).
  - d_last = d_out_vld & (counter==WIDTH-1).
  - busy = (state==SHIFT) | hold_full.
- Accept versus last bit: an accept and a last-bit reload in the same cycle cannot conflict. An accept requires hold_full=0, so the bypass path is used.
- Counter width: $clog2(WIDTH). The counter wraps only via an explicit reload to 0, never by overflow.
- Reset mid-word: the partial word and any held word are discarded. No d_last is emitted. Output is quiet the cycle after reset.
- d_in_vld may drop without an accept; no state changes.

Decomposition:
- Package transfer_pkg holds:
  - default WIDTH constant;
  - state enum {IDLE, SHIFT};
  - function for the counter width.
- One natural sub-module, transfer_hold_buf: a one-entry register plus full flag with load/unload strobes, instantiated once.
- The FSM, shifter and counter stay in transfer_4to1.

Test Plan:
- Reset held 3 cycles, then released, no input → all outputs 0, d_in_rdy=1 on the first cycle after release.
- WIDTH=4, MSB_FIRST=1; accept 4'b1011 at cycle N → d_out=1,0,1,1 on cycles N+1..N+4; d_first at N+1, d_last at N+4; idle at N+5.
- MSB_FIRST=0, single word 4'b1011 → d_out=1,1,0,1.
- Back-to-back 4'hA, 4'h5, 4'hF with d_in_vld held high:
  - 12 consecutive valid bits 1010_0101_1111;
  - d_first every 4th cycle;
  - d_in_rdy drops while hold is full.
- Accept 4'hC, then assert rst_n=0 after the second bit → outputs 0 next cycle, no d_last; post-reset word 4'h3 serializes cleanly as 0011.
- Loopback into transfer_1to4 with 16 random words → reassembled words match the sent words in order.
